ad9866_spi_reader: RTL and testbench
====================================

// Module: ad9866_spi_reader
// PURPOSE
//  AD9866 register read-back engine. It issues a single-byte SPI read
//  (4-wire mode) and returns the byte clocked out on ad9866_sdo.
//  It is the receive-direction counterpart of the existing AD9866 SPI
//  register writer. It runs on the ad9866spiclk domain inside
//  hermes_lite_core. The core muxes its sclk/sdio/sen_n onto the AD9866
//  pins while busy is high.
// PARAMETERS
//  CLK_DIV   4   sclk half-period in clk cycles (>=1); sclk = clk/(2*CLK_DIV)
// PORTS
//  clk          in   1  ad9866spiclk; all logic on rising edge
//  reset        in   1  asynchronous, active-high
//  start        in   1  one-cycle request; accepted only in IDLE
//  addr         in   6  AD9866 register address, captured when start is accepted
//  busy         out  1  high from the accept cycle through the HOLD phase
//  done         out  1  one-cycle pulse; rdata valid from this cycle
//  rdata        out  8  last byte read; holds until the next done
//  sclk         out  1  SPI clock to AD9866 (idle low)
//  sdio         out  1  SPI instruction data to AD9866
//  sdo          in   1  SPI read data from AD9866
//  sen_n        out  1  SPI chip enable, active low (idle high)
// BEHAVIOUR
//  Reset values
//  - sen_n=1, sclk=0, sdio=0, busy=0, done=0, rdata=8'h00; state=IDLE.
//  - Reset asserted mid-transfer aborts the transfer immediately and
//    forces these same values.
//  - No done pulse is issued for an aborted transfer.
//  Frame
//  - 24 bits, MSB first: instr[15:0] then data[7:0].
//  - instr = {1'b1 (read), 2'b00 (1 byte), 7'b0, addr[5:0]}.
//  States
//  - IDLE: on start=1, latch addr, set busy=1, sen_n=0 -> SETUP.
//  - SETUP: sclk=0, sdio=instr[15]; hold CLK_DIV cycles -> SHIFT.
//  - SHIFT: 24 bit slots; each slot is CLK_DIV cycles with sclk=0, then
//    CLK_DIV cycles with sclk=1.
//    - sdio changes only at the start of a low phase (slot 0 uses the
//      SETUP value).
//    - sdio=0 during slots 16..23.
//    - In slots 16..23, sdo is registered on the clk edge that drives
//      sclk 0->1 and shifted into a shift register, MSB first.
//    - After the high phase of slot 23 -> HOLD.
//  - HOLD: sclk=0, sen_n=0 for CLK_DIV cycles -> DONE.
//  - DONE (one cycle): sen_n=1, busy=0, done=1,
//    rdata <= shift register -> IDLE.
//  Timing
//  - If start is accepted in cycle 0, done is high in cycle 50*CLK_DIV+1.
//  - Exactly 24 sclk rising edges per transfer.
//  Boundaries
//  - start while busy=1, or in the DONE cycle: ignored, no queueing.
//    A new start is accepted from the cycle after DONE.
//  - Back-to-back transfers: sen_n is high for at least 1 clk between frames.
//  - The bit counter is 5 bits and saturates at the frame end.
//  - The divider counter reloads at every phase change and never wraps
//    mid-phase.
// TESTING
//  1) CLK_DIV=4, start with addr=6'h0A, model returns 8'hA5:
//     sdio serial = 16'h800A; rdata=8'hA5; done in cycle 201; 24 sclk edges.
//  2) start pulsed again at cycle 50 of (1): ignored; exactly one done;
//     addr latch unchanged.
//  3) reset asserted at cycle 100 of a read: sen_n=1 and sclk=0 at once,
//     no done; the next read of 6'h13 (model 8'h3C) returns 8'h3C.
//  4) CLK_DIV=1, addr=6'h3F, model returns 8'h01: instr=16'h803F;
//     rdata=8'h01; done in cycle 51.
//  5) Two starts, the second in the cycle after done, reading 8'hFF then 8'h00:
//     sen_n high for >=1 cycle between frames; rdata=8'hFF, then 8'h00.
//  6) Protocol check: sdio is stable while sclk is high, and sen_n stays low
//     for the whole frame.

Source files
------------

// File: rtl/ad9866_spi_reader.sv
// AD9866 register read-back engine: issues a 4-wire single-byte SPI read and
// returns the byte shifted in on sdo. All outputs are registered.
module ad9866_spi_reader #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] addr,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       sdio,
  input  logic       sdo,
  output logic       sen_n
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0] LAST_SLOT  = 5'd23;
  localparam logic [4:0] FIRST_DATA = 5'd16;
  localparam logic [4:0] SLOT_SAT   = 5'd24;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [14:0]      instr_q, instr_d;   // instr[14:0]; bit 15 (read flag) is driven in SETUP
  logic [7:0]       shreg_q, shreg_d;
  logic             sclk_d, sdio_d, sen_n_d, busy_d, done_d;
  logic [7:0]       rdata_d;
  logic             div_zero;

  assign div_zero = (div_q == '0);

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      instr_q <= '0;
      shreg_q <= '0;
      sclk    <= 1'b0;
      sdio    <= 1'b0;
      sen_n   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= 8'h00;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      instr_q <= instr_d;
      shreg_q <= shreg_d;
      sclk    <= sclk_d;
      sdio    <= sdio_d;
      sen_n   <= sen_n_d;
      busy    <= busy_d;
      done    <= done_d;
      rdata   <= rdata_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    instr_d = instr_q;
    shreg_d = shreg_q;
    sclk_d  = sclk;
    sdio_d  = sdio;
    sen_n_d = sen_n;
    busy_d  = busy;
    done_d  = 1'b0;
    rdata_d = rdata;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          busy_d  = 1'b1;
          sen_n_d = 1'b0;
          sclk_d  = 1'b0;
          sdio_d  = 1'b1;
          instr_d = {2'b00, 7'b0, addr};
          div_d   = DIV_LOAD;
          bit_d   = '0;
        end
      end

      SETUP: begin
        if (div_zero) begin
          state_d = SHIFT;
          div_d   = DIV_LOAD;
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      SHIFT: begin
        if (!div_zero) begin
          div_d = div_q - 1'b1;
        end else begin
          div_d = DIV_LOAD;
          if (!sclk) begin
            // Rising sclk edge: sample read data during the data byte
            sclk_d = 1'b1;
            if (bit_q >= FIRST_DATA) shreg_d = {shreg_q[6:0], sdo};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == LAST_SLOT) begin
              state_d = HOLD;
              bit_d   = SLOT_SAT;
              sdio_d  = 1'b0;
            end else begin
              // Zeros shift in behind the instruction, so sdio is 0 in the data byte
              bit_d   = bit_q + 5'd1;
              sdio_d  = instr_q[14];
              instr_d = {instr_q[13:0], 1'b0};
            end
          end
        end
      end

      HOLD: begin
        if (div_zero) begin
          state_d = DONE;
          sen_n_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rdata_d = shreg_q;
        end else begin
          div_d = div_q - 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ad9866_spi_reader.sv
// Directed bench for ad9866_spi_reader: two instances (CLK_DIV=4 and 1) with a
// behavioural AD9866 sdo model and a protocol monitor.
module tb_ad9866_spi_reader;

  logic       clk = 1'b0;
  logic       rst   [2];
  logic       start [2];
  logic [5:0] addr  [2];
  logic       busy  [2];
  logic       done  [2];
  logic [7:0] rdata [2];
  logic       sclk  [2];
  logic       sdio  [2];
  logic       sdo   [2];
  logic       sen_n [2];

  always #5 clk = ~clk;

  ad9866_spi_reader #(.CLK_DIV(4)) u_div4 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .addr(addr[0]),
    .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
    .sclk(sclk[0]), .sdio(sdio[0]), .sdo(sdo[0]), .sen_n(sen_n[0]));

  ad9866_spi_reader #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .addr(addr[1]),
    .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
    .sclk(sclk[1]), .sdio(sdio[1]), .sdo(sdo[1]), .sen_n(sen_n[1]));

  int nchk = 0;
  int nerr = 0;

  // Monitor / device model state (written only by the monitor process)
  int          slots    [2];
  int          viol     [2];
  int          done_cnt [2];
  int          frames   [2];
  int          hi_run   [2];
  int          last_gap [2];
  logic [15:0] cap      [2];
  logic        prev_sclk  [2];
  logic        prev_sdio  [2];
  logic        prev_sen_n [2];
  logic [7:0]  model_data [2];

  // Sampled mid-cycle: tracks frames, captures instruction bits, drives sdo
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (sen_n[g] === 1'b0 && prev_sen_n[g] === 1'b1) begin
        slots[g]    = 0;
        cap[g]      = '0;
        last_gap[g] = hi_run[g];
        frames[g]   = frames[g] + 1;
      end
      hi_run[g] = (sen_n[g] === 1'b1) ? hi_run[g] + 1 : 0;
      if (sclk[g] === 1'b1 && prev_sclk[g] === 1'b0) begin
        if (slots[g] < 16) cap[g] = {cap[g][14:0], sdio[g]};
        slots[g] = slots[g] + 1;
      end
      if (sclk[g] === 1'b1 && prev_sclk[g] === 1'b1 && sdio[g] !== prev_sdio[g]) viol[g] = viol[g] + 1;
      if (sclk[g] === 1'b1 && sen_n[g] !== 1'b0) viol[g] = viol[g] + 1;
      if (sen_n[g] !== !busy[g]) viol[g] = viol[g] + 1;
      if (done[g] === 1'b1) done_cnt[g] = done_cnt[g] + 1;
      sdo[g] = (sclk[g] === 1'b0 && slots[g] >= 16 && slots[g] < 24) ?
               model_data[g][23 - slots[g]] : 1'b0;
      prev_sclk[g]  = sclk[g];
      prev_sdio[g]  = sdio[g];
      prev_sen_n[g] = sen_n[g];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One read; returns in the done cycle (or after the budget expires, dcyc=-1)
  task automatic run_read(input int i, input logic [5:0] a, input logic [7:0] d,
                          input int extra_at, output int dcyc, output logic [15:0] instr,
                          output logic [7:0] rd, output int edges);
    int cyc;
    model_data[i] = d;
    step();
    addr[i]  = a;
    start[i] = 1'b1;
    cyc  = 0;
    dcyc = -1;
    step();
    addr[i] = ~a;
    cyc = 1;
    while (cyc < 400) begin
      start[i] = (cyc == extra_at);
      if (done[i] === 1'b1) begin
        dcyc = cyc;
        break;
      end
      step();
      cyc++;
    end
    start[i] = 1'b0;
    instr = cap[i];
    rd    = rdata[i];
    edges = slots[i];
  endtask

  typedef struct {
    int         inst;
    logic [5:0] a;
    logic [7:0] d;
    int         exp_cyc;
    logic [15:0] exp_instr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          dcyc, edges, base, fbase;
    logic [15:0] instr;
    logic [7:0]  rd;

    vecs[0] = '{0, 6'h0A, 8'hA5, 201, 16'h800A};
    vecs[1] = '{1, 6'h3F, 8'h01, 51,  16'h803F};
    vecs[2] = '{0, 6'h13, 8'h3C, 201, 16'h8013};
    vecs[3] = '{1, 6'h00, 8'hFF, 51,  16'h8000};
    vecs[4] = '{1, 6'h2A, 8'h5A, 51,  16'h802A};
    vecs[5] = '{0, 6'h15, 8'h80, 201, 16'h8015};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; addr[i] = '0; model_data[i] = '0;
    end
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      chk("rst_sen_n", 32'(sen_n[i]), 32'd1);
      chk("rst_sclk",  32'(sclk[i]),  32'd0);
      chk("rst_sdio",  32'(sdio[i]),  32'd0);
      chk("rst_busy",  32'(busy[i]),  32'd0);
      chk("rst_done",  32'(done[i]),  32'd0);
      chk("rst_rdata", 32'(rdata[i]), 32'd0);
      rst[i] = 1'b0;
    end
    repeat (2) step();

    // Table-driven reads
    foreach (vecs[k]) begin
      run_read(vecs[k].inst, vecs[k].a, vecs[k].d, -1, dcyc, instr, rd, edges);
      chk("vec_rdata", 32'(rd), 32'(vecs[k].d));
      chk("vec_instr", 32'(instr), 32'(vecs[k].exp_instr));
      chk("vec_done_cycle", 32'(dcyc), 32'(vecs[k].exp_cyc));
      chk("vec_sclk_edges", 32'(edges), 32'd24);
      repeat (2) step();
    end

    // Second start while busy is ignored
    base = done_cnt[0];
    run_read(0, 6'h0A, 8'hA5, 50, dcyc, instr, rd, edges);
    chk("busy_start_rdata", 32'(rd), 32'hA5);
    chk("busy_start_instr", 32'(instr), 32'h800A);
    chk("busy_start_cycle", 32'(dcyc), 32'd201);
    repeat (30) step();
    chk("busy_start_one_done", 32'(done_cnt[0] - base), 32'd1);
    chk("busy_start_idle", 32'(busy[0]), 32'd0);

    // Reset mid-transfer aborts at once with no done
    base = done_cnt[0];
    model_data[0] = 8'h77;
    addr[0] = 6'h21; start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (99) step();
    chk("abort_was_busy", 32'(busy[0]), 32'd1);
    rst[0] = 1'b1;
    #1;
    chk("abort_sen_n", 32'(sen_n[0]), 32'd1);
    chk("abort_sclk",  32'(sclk[0]),  32'd0);
    chk("abort_busy",  32'(busy[0]),  32'd0);
    repeat (2) step();
    rst[0] = 1'b0;
    repeat (250) step();
    chk("abort_no_done", 32'(done_cnt[0] - base), 32'd0);
    chk("abort_rdata_cleared", 32'(rdata[0]), 32'd0);
    run_read(0, 6'h13, 8'h3C, -1, dcyc, instr, rd, edges);
    chk("after_abort_rdata", 32'(rd), 32'h3C);
    chk("after_abort_instr", 32'(instr), 32'h8013);

    // Start in the DONE cycle is ignored
    fbase = frames[1];
    run_read(1, 6'h05, 8'hC3, -1, dcyc, instr, rd, edges);
    chk("done_start_rdata", 32'(rd), 32'hC3);
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    chk("done_start_busy", 32'(busy[1]), 32'd0);
    repeat (5) step();
    chk("done_start_frames", 32'(frames[1] - fbase), 32'd1);

    // Back-to-back: second start in the cycle after done
    fbase = frames[1];
    run_read(1, 6'h11, 8'hFF, -1, dcyc, instr, rd, edges);
    chk("b2b_first_rdata", 32'(rd), 32'hFF);
    run_read(1, 6'h12, 8'h00, -1, dcyc, instr, rd, edges);
    chk("b2b_second_rdata", 32'(rd), 32'h00);
    chk("b2b_second_cycle", 32'(dcyc), 32'd51);
    chk("b2b_frames", 32'(frames[1] - fbase), 32'd2);
    chk("b2b_gap_ok", 32'(last_gap[1] >= 1), 32'd1);
    repeat (3) step();
    chk("b2b_rdata_holds", 32'(rdata[1]), 32'h00);

    chk("protocol_div4", 32'(viol[0]), 32'd0);
    chk("protocol_div1", 32'(viol[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
